// File: rtl/ysyx_22050019_ifu_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// ysyx_22050019_ifu_pkg: shared IFU constants and fetch-entry type.
// Rev 1.0
// ------------------------------------------------------------------
package ysyx_22050019_ifu_pkg;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [31:0] NOP_INST    = 32'h0000_0013;
  localparam int unsigned ENTRY_PC_W  = 64;

  typedef struct packed {
    logic [ENTRY_PC_W-1:0] pc;
    logic [31:0]           inst;
    logic                  fault;
  } fetch_entry_t;

  function automatic logic resp_is_fault(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22050019_sync_fifo.sv
`default_nettype none
// ------------------------------------------------------------------
// ysyx_22050019_sync_fifo: flushable synchronous FIFO, head shown combinationally.
// Rev 1.0
// ------------------------------------------------------------------
module ysyx_22050019_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is accepted only when the head leaves the same cycle.
  assign do_pop    = pop && (count != '0);
  assign do_push   = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_22050019_ifu_prefetch.sv
`default_nettype none
// ------------------------------------------------------------------
// ysyx_22050019_ifu_prefetch: credit-based AXI instruction prefetcher feeding IDU.
// Rev 1.0
// ------------------------------------------------------------------
module ysyx_22050019_ifu_prefetch #(
  parameter int unsigned       ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] RESET_VAL = 64'h8000_0000,
  parameter int unsigned       DATA_W    = 64,
  parameter int unsigned       DEPTH     = 4,
  parameter int unsigned       MAX_OUTST = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic              if_valid_o,
  input  logic              id_ready_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [31:0]       inst_o,
  output logic              fault_o
);

  import ysyx_22050019_ifu_pkg::*;

  localparam int unsigned OFF     = $clog2(DATA_W / 8);
  localparam int unsigned CW      = $clog2(DEPTH) + 1;
  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] ar_pc;
  logic [ADDR_W-1:0] pc_base;
  logic [ADDR_W-1:0] tag_pc;
  logic              arvalid_q;
  logic              rready_q;
  logic              ar_stale;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     inflight_nxt;
  logic [CW-1:0]     drop_cnt;
  logic [CW-1:0]     occupancy;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     tag_count;
  logic              ar_hs;
  logic              r_beat;
  logic              drop_beat;
  logic              keep_beat;
  logic              issue_ok;
  logic              beat_fault;
  logic [31:0]       beat_inst;
  fetch_entry_t      push_entry;
  fetch_entry_t      head_entry;
  logic [ENTRY_W-1:0] head_bits;

  assign ar_hs        = arvalid_q && m_axi_arready;
  assign r_beat       = m_axi_rvalid && rready_q;
  assign drop_beat    = r_beat && (drop_cnt != '0);
  assign keep_beat    = r_beat && (drop_cnt == '0) && !redirect_i && (tag_count != '0);
  assign inflight_nxt = inflight + CW'(ar_hs) - CW'(r_beat);

  // Outstanding reads always own a FIFO slot, so the prefetch FIFO can never overflow.
  assign occupancy = (redirect_i ? '0 : fifo_count) + inflight + CW'(ar_hs);
  assign issue_ok  = (occupancy < CW'(DEPTH)) && (inflight_nxt < CW'(MAX_OUTST));

  // A stale AR (issued before a redirect) must not advance the already-redirected fetch PC.
  always_comb begin
    pc_base = fetch_pc;
    if (redirect_i) begin
      pc_base = redirect_pc_i;
    end else if (ar_hs && !ar_stale) begin
      pc_base = fetch_pc + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc  <= RESET_VAL;
      ar_pc     <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      ar_stale  <= 1'b0;
      inflight  <= '0;
      drop_cnt  <= '0;
    end else begin
      rready_q <= 1'b1;
      fetch_pc <= pc_base;
      inflight <= inflight_nxt;
      if (redirect_i) begin
        drop_cnt <= inflight_nxt;
      end else begin
        drop_cnt <= drop_cnt + CW'(ar_hs && ar_stale) - CW'(drop_beat);
      end
      // An offered AR stays frozen until accepted, even if a redirect retargets fetch.
      if (!arvalid_q || m_axi_arready) begin
        arvalid_q <= issue_ok;
        ar_stale  <= 1'b0;
        if (issue_ok) ar_pc <= pc_base;
      end else if (redirect_i) begin
        ar_stale <= 1'b1;
      end
    end
  end

  assign m_axi_arvalid = arvalid_q;
  assign m_axi_araddr  = {ar_pc[ADDR_W-1:OFF], {OFF{1'b0}}};
  assign m_axi_rready  = rready_q;

  ysyx_22050019_sync_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_i),
    .push      (ar_hs && !ar_stale && !redirect_i),
    .push_data (ar_pc),
    .pop       (keep_beat),
    .head_data (tag_pc),
    .count     (tag_count)
  );

  generate
    if (DATA_W == 32) begin : g_sel_single
      assign beat_inst = m_axi_rdata;
    end else begin : g_sel_lane
      logic [OFF-3:0] lane;
      assign lane      = tag_pc[OFF-1:2];
      assign beat_inst = m_axi_rdata[lane*32 +: 32];
    end
  endgenerate

  assign beat_fault = resp_is_fault(m_axi_rresp);

  always_comb begin
    push_entry       = '0;
    push_entry.pc    = ENTRY_PC_W'(tag_pc);
    push_entry.inst  = beat_fault ? NOP_INST : beat_inst;
    push_entry.fault = beat_fault;
  end

  ysyx_22050019_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_prefetch_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_i),
    .push      (keep_beat),
    .push_data (push_entry),
    .pop       (if_valid_o && id_ready_i && !redirect_i),
    .head_data (head_bits),
    .count     (fifo_count)
  );

  assign head_entry = head_bits;
  assign if_valid_o = (fifo_count != '0);
  assign pc_o       = if_valid_o ? ADDR_W'(head_entry.pc) : '0;
  assign inst_o     = if_valid_o ? head_entry.inst : '0;
  assign fault_o    = if_valid_o && head_entry.fault;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050019_ifu_prefetch.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_ysyx_22050019_ifu_prefetch: directed bench with a small AXI read slave model.
// Rev 1.0
// ------------------------------------------------------------------
module tb_ysyx_22050019_ifu_prefetch;

  import ysyx_22050019_ifu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic [63:0] m_axi_araddr;
  logic        m_axi_arvalid;
  logic        m_axi_arready = 1'b0;
  logic [63:0] m_axi_rdata = '0;
  logic [1:0]  m_axi_rresp = 2'b00;
  logic        m_axi_rvalid = 1'b0;
  logic        m_axi_rready;
  logic        if_valid;
  logic        id_ready = 1'b1;
  logic [63:0] pc_o;
  logic [31:0] inst_o;
  logic        fault_o;

  typedef struct { logic [63:0] addr; int due; bit fault; } req_t;
  typedef struct { logic [63:0] pc; logic [31:0] inst; logic fault; } idu_t;

  req_t        rq[$];
  logic [63:0] ar_log[$];
  idu_t        idu_log[$];
  int cyc = 0, lat = 0, ar_seq = 0, fault_seq = -1;
  int passed = 0, total = 0;

  ysyx_22050019_ifu_prefetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .if_valid_o    (if_valid),
    .id_ready_i    (id_ready),
    .pc_o          (pc_o),
    .inst_o        (inst_o),
    .fault_o       (fault_o)
  );

  always #5 clk = ~clk;

  // Memory image: the instruction at any PC p is p[31:0] + 0x1111_0000.
  function automatic logic [63:0] beat(input logic [63:0] a);
    logic [31:0] lo;
    lo = a[31:0];
    return {lo + 32'h1111_0004, lo + 32'h1111_0000};
  endfunction

  // Handshake bookkeeping at the edge (reads pre-edge values).
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      rq.delete();
      ar_seq = 0;
    end else begin
      if (m_axi_rvalid && m_axi_rready && rq.size() > 0) void'(rq.pop_front());
      if (m_axi_arvalid && m_axi_arready) begin
        rq.push_back('{m_axi_araddr, cyc + lat, (ar_seq == fault_seq)});
        ar_log.push_back(m_axi_araddr);
        ar_seq = ar_seq + 1;
      end
      if (if_valid && id_ready) idu_log.push_back('{pc_o, inst_o, fault_o});
    end
  end

  always @(negedge clk) begin
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = beat(rq[0].addr);
      m_axi_rresp  = rq[0].fault ? RESP_SLVERR : RESP_OKAY;
    end else begin
      m_axi_rvalid = 1'b0;
      m_axi_rdata  = '0;
      m_axi_rresp  = RESP_OKAY;
    end
  end

  function automatic logic [63:0] ar_at(input int i);
    if (i < ar_log.size()) return ar_log[i];
    return 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  function automatic idu_t idu_at(input int i);
    idu_t e;
    e = '{64'hDEAD_DEAD_DEAD_DEAD, 32'hDEAD_DEAD, 1'bx};
    if (i < idu_log.size()) e = idu_log[i];
    return e;
  endfunction

  task automatic do_reset(input bit ar_rdy);
    @(negedge clk);
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b1;
    m_axi_arready = ar_rdy; lat = 0; fault_seq = -1;
    repeat (2) @(negedge clk);
    ar_log.delete(); idu_log.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_idu(input int n, input string tag);
    int k = 0;
    while (idu_log.size() < n && k < 80) begin @(negedge clk); k++; end
    if (idu_log.size() < n) begin
      total++;
      $display("FAIL %s_timeout: got %0d entries, want %0d", tag, idu_log.size(), n);
    end
  endtask

  task automatic wait_ar(input int n, input string tag);
    int k = 0;
    while (ar_log.size() < n && k < 80) begin @(negedge clk); k++; end
    if (ar_log.size() < n) begin
      total++;
      $display("FAIL %s_timeout: got %0d ARs, want %0d", tag, ar_log.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; id_ready = 1'b1; m_axi_arready = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (m_axi_arvalid !== 1'b0) $display("FAIL rst_arvalid: got %b want 0", m_axi_arvalid); else passed++;
    total++; if (m_axi_rready !== 1'b0) $display("FAIL rst_rready: got %b want 0", m_axi_rready); else passed++;
    total++; if (if_valid !== 1'b0) $display("FAIL rst_if_valid: got %b want 0", if_valid); else passed++;
    total++; if (pc_o !== 64'h0) $display("FAIL rst_pc: got %h want 0", pc_o); else passed++;
    total++; if (inst_o !== 32'h0) $display("FAIL rst_inst: got %h want 0", inst_o); else passed++;
    total++; if (fault_o !== 1'b0) $display("FAIL rst_fault: got %b want 0", fault_o); else passed++;
    ar_log.delete(); idu_log.delete();
    rst_n = 1'b1;
    @(negedge clk);
    total++; if ({m_axi_arvalid, m_axi_araddr} !== {1'b1, 64'h8000_0000})
      $display("FAIL first_ar: got %b/%h want 1/80000000", m_axi_arvalid, m_axi_araddr); else passed++;
    total++; if (m_axi_rready !== 1'b1) $display("FAIL rready_on: got %b want 1", m_axi_rready); else passed++;
    @(negedge clk);
    total++; if ({m_axi_arvalid, m_axi_araddr} !== {1'b1, 64'h8000_0000})
      $display("FAIL ar_hold: got %b/%h want 1/80000000", m_axi_arvalid, m_axi_araddr); else passed++;
  endtask

  task automatic test_stream();
    idu_t e;
    do_reset(1'b1);
    wait_idu(3, "stream");
    total++; if (ar_at(0) !== 64'h8000_0000) $display("FAIL stream_ar0: got %h want 80000000", ar_at(0)); else passed++;
    total++; if (ar_at(1) !== 64'h8000_0000) $display("FAIL stream_ar1: got %h want 80000000", ar_at(1)); else passed++;
    total++; if (ar_at(2) !== 64'h8000_0008) $display("FAIL stream_ar2: got %h want 80000008", ar_at(2)); else passed++;
    e = idu_at(0);
    total++; if ({e.pc, e.inst, e.fault} !== {64'h8000_0000, 32'h9111_0000, 1'b0})
      $display("FAIL stream_e0: got %h/%h/%b want 80000000/91110000/0", e.pc, e.inst, e.fault); else passed++;
    e = idu_at(1);
    total++; if ({e.pc, e.inst, e.fault} !== {64'h8000_0004, 32'h9111_0004, 1'b0})
      $display("FAIL stream_e1: got %h/%h/%b want 80000004/91110004/0", e.pc, e.inst, e.fault); else passed++;
    e = idu_at(2);
    total++; if ({e.pc, e.inst} !== {64'h8000_0008, 32'h9111_0008})
      $display("FAIL stream_e2: got %h/%h want 80000008/91110008", e.pc, e.inst); else passed++;
  endtask

  task automatic test_full();
    idu_t e;
    do_reset(1'b1);
    id_ready = 1'b0;
    repeat (20) @(negedge clk);
    total++; if (ar_log.size() != 4) $display("FAIL full_ar_count: got %0d want 4", ar_log.size()); else passed++;
    total++; if (m_axi_arvalid !== 1'b0) $display("FAIL full_arvalid: got %b want 0", m_axi_arvalid); else passed++;
    total++; if ({if_valid, pc_o, inst_o} !== {1'b1, 64'h8000_0000, 32'h9111_0000})
      $display("FAIL full_head: got %b/%h/%h want 1/80000000/91110000", if_valid, pc_o, inst_o); else passed++;
    total++; if (idu_log.size() != 0) $display("FAIL full_no_pop: got %0d want 0", idu_log.size()); else passed++;
    id_ready = 1'b1;
    wait_idu(5, "full_drain");
    e = idu_at(3);
    total++; if ({e.pc, e.inst} !== {64'h8000_000C, 32'h9111_000C})
      $display("FAIL full_e3: got %h/%h want 8000000c/9111000c", e.pc, e.inst); else passed++;
    e = idu_at(4);
    total++; if (e.pc !== 64'h8000_0010) $display("FAIL full_e4: got %h want 80000010", e.pc); else passed++;
  endtask

  task automatic test_redirect_pending();
    idu_t e;
    do_reset(1'b0);
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 64'h8000_1000;
    @(negedge clk);
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if ({m_axi_arvalid, m_axi_araddr} !== {1'b1, 64'h8000_0000})
        $display("FAIL rdp_hold%0d: got %b/%h want 1/80000000", i, m_axi_arvalid, m_axi_araddr); else passed++;
      @(negedge clk);
    end
    m_axi_arready = 1'b1;
    wait_idu(1, "rdp");
    total++; if (ar_at(0) !== 64'h8000_0000) $display("FAIL rdp_ar0: got %h want 80000000", ar_at(0)); else passed++;
    total++; if (ar_at(1) !== 64'h8000_1000) $display("FAIL rdp_ar1: got %h want 80001000", ar_at(1)); else passed++;
    e = idu_at(0);
    total++; if ({e.pc, e.inst} !== {64'h8000_1000, 32'h9111_1000})
      $display("FAIL rdp_first: got %h/%h want 80001000/91111000", e.pc, e.inst); else passed++;
  endtask

  task automatic test_drop_inflight();
    idu_t e;
    bit any_valid;
    do_reset(1'b1);
    lat = 3;
    wait_ar(2, "drop");
    redirect = 1'b1; redirect_pc = 64'h8000_2000;
    @(negedge clk);
    redirect = 1'b0;
    any_valid = 1'b0;
    repeat (6) begin
      if (if_valid !== 1'b0) any_valid = 1'b1;
      @(negedge clk);
    end
    total++; if (any_valid !== 1'b0) $display("FAIL drop_window: got valid=1 want 0"); else passed++;
    wait_idu(1, "drop");
    e = idu_at(0);
    total++; if ({e.pc, e.inst} !== {64'h8000_2000, 32'h9111_2000})
      $display("FAIL drop_first: got %h/%h want 80002000/91112000", e.pc, e.inst); else passed++;
    total++; if (ar_at(2) !== 64'h8000_2000) $display("FAIL drop_ar2: got %h want 80002000", ar_at(2)); else passed++;
  endtask

  task automatic test_fault();
    idu_t e;
    do_reset(1'b1);
    fault_seq = 1;
    wait_idu(3, "fault");
    e = idu_at(0);
    total++; if (e.fault !== 1'b0) $display("FAIL fault_e0: got %b want 0", e.fault); else passed++;
    e = idu_at(1);
    total++; if ({e.pc, e.inst, e.fault} !== {64'h8000_0004, 32'h0000_0013, 1'b1})
      $display("FAIL fault_e1: got %h/%h/%b want 80000004/00000013/1", e.pc, e.inst, e.fault); else passed++;
    e = idu_at(2);
    total++; if ({e.pc, e.inst, e.fault} !== {64'h8000_0008, 32'h9111_0008, 1'b0})
      $display("FAIL fault_e2: got %h/%h/%b want 80000008/91110008/0", e.pc, e.inst, e.fault); else passed++;
  endtask

  task automatic test_reset_mid();
    idu_t e;
    do_reset(1'b1);
    id_ready = 1'b0;
    wait_ar(3, "rmid");
    lat = 30;
    repeat (3) @(negedge clk);
    total++; if ({ar_log.size() == 4, m_axi_arvalid, if_valid} !== 3'b101)
      $display("FAIL rmid_pre: got ars=%0d arvalid=%b valid=%b want 4/0/1", ar_log.size(), m_axi_arvalid, if_valid); else passed++;
    rst_n = 1'b0;
    @(negedge clk);
    total++; if ({if_valid, m_axi_arvalid} !== 2'b00)
      $display("FAIL rmid_clear: got valid=%b arvalid=%b want 0/0", if_valid, m_axi_arvalid); else passed++;
    total++; if (pc_o !== 64'h0) $display("FAIL rmid_pc: got %h want 0", pc_o); else passed++;
    ar_log.delete(); idu_log.delete();
    lat = 0; id_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    total++; if ({m_axi_arvalid, m_axi_araddr} !== {1'b1, 64'h8000_0000})
      $display("FAIL rmid_restart: got %b/%h want 1/80000000", m_axi_arvalid, m_axi_araddr); else passed++;
    wait_idu(1, "rmid");
    e = idu_at(0);
    total++; if (e.pc !== 64'h8000_0000) $display("FAIL rmid_first: got %h want 80000000", e.pc); else passed++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_redirect_pending();
    test_drop_inflight();
    test_fault();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1);
  end

endmodule
`default_nettype wire
